tdm_sync_ctrl: RTL and testbench

- Lock controller for the 4-channel 108 MHz TW2866/TW2867 byte-interleaved BT656 bus.
- Watches the raw 108 MHz stream and finds the FF 00 00 XY timing preambles inside each byte slot.
- Uses the channel ID nibble carried in XY to decide which slot carries channel 0, then publishes that slot assignment with a qualified lock flag.
- Downstream channel demux and frame-store logic use the published assignment instead of re-deriving it per channel.

---
 rtl/tdm_sync_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_tdm_sync_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_sync_ctrl.sv
// Lock controller for a 4-channel byte-interleaved BT656 bus: finds FF 00 00 XY preambles per slot
// and publishes which slot carries channel 0. Optional err_cnt port via TDM_SYNC_ERR_CNT_EN.
module tdm_sync_ctrl #(
  parameter int LOCK_CNT    = 4,
  parameter int MISS_LIMIT  = 3,
  parameter int TIMEOUT_CYC = 16384
) (
  input  logic       clk_108m,
  input  logic       rst_n,
  input  logic [7:0] vin_data,
  output logic [1:0] slot_cnt,
  output logic [1:0] ch0_slot,
  output logic       lock,
  output logic       lock_lost,
  output logic       sync_det,
  output logic [1:0] det_id
`ifdef TDM_SYNC_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam logic [3:0]  LOCK_W    = 4'(LOCK_CNT);
  localparam logic [3:0]  MISS_W    = 4'(MISS_LIMIT);
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYC);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  s0_reg;
  logic [7:0]  tap_reg [0:11];
  logic [1:0]  slot_reg;
  logic [15:0] tcnt_reg;
  logic [1:0]  stored_reg, stored_next;
  logic [3:0]  match_reg, match_next;
  logic [3:0]  miss_reg, miss_next;
  logic [1:0]  ch0_reg, ch0_next;
  logic        lock_reg, lock_next;
  logic        lost_reg, lost_next;
  logic        sync_reg;
  logic [1:0]  det_id_reg;
  logic        pre_pat, valid, timeout;
  logic [1:0]  id, cand;
  logic [3:0]  match_inc, miss_inc;

  // tap_reg[3/7/11] hold the bytes of this same slot 1/2/3 slot-periods ago
  always_ff @(posedge clk_108m or negedge rst_n) begin
    if (!rst_n) begin
      s0_reg   <= 8'h00;
      slot_reg <= 2'd0;
      for (int i = 0; i < 12; i++) tap_reg[i] <= 8'h00;
    end else begin
      s0_reg     <= vin_data;
      slot_reg   <= slot_reg + 2'd1;
      tap_reg[0] <= s0_reg;
      for (int i = 1; i < 12; i++) tap_reg[i] <= tap_reg[i-1];
    end
  end

  assign pre_pat = (tap_reg[11] == 8'hFF) && (tap_reg[7] == 8'h00) && (tap_reg[3] == 8'h00);
  assign valid   = pre_pat && s0_reg[7] && (s0_reg[3:2] == 2'b00);
  assign id      = s0_reg[1:0];
  assign cand    = slot_reg - id;
  assign timeout = (tcnt_reg == TIMEOUT_W);

  always_ff @(posedge clk_108m or negedge rst_n) begin
    if (!rst_n)       tcnt_reg <= 16'd0;
    else if (valid)   tcnt_reg <= 16'd0;
    else if (!timeout) tcnt_reg <= tcnt_reg + 16'd1;
  end

  assign match_inc = (match_reg == 4'd15) ? 4'd15 : match_reg + 4'd1;
  assign miss_inc  = (miss_reg == 4'd15) ? 4'd15 : miss_reg + 4'd1;

`ifdef TDM_SYNC_ERR_CNT_EN
  logic [7:0] err_reg, err_next;
  assign err_cnt = err_reg;
`endif

  always_comb begin
    state_next  = state_reg;
    stored_next = stored_reg;
    match_next  = match_reg;
    miss_next   = miss_reg;
    ch0_next    = ch0_reg;
    lock_next   = lock_reg;
    lost_next   = 1'b0;
`ifdef TDM_SYNC_ERR_CNT_EN
    err_next    = err_reg;
`endif
    case (state_reg)
      SEARCH: begin
        if (valid) begin
          stored_next = cand;
          match_next  = 4'd1;
          if (LOCK_W <= 4'd1) begin
            state_next = LOCKED;
            ch0_next   = cand;
            lock_next  = 1'b1;
            miss_next  = 4'd0;
          end else begin
            state_next = VERIFY;
          end
        end
      end
      VERIFY: begin
        if (valid) begin
          if (cand == stored_reg) begin
            match_next = match_inc;
            if (match_inc >= LOCK_W) begin
              state_next = LOCKED;
              ch0_next   = cand;
              lock_next  = 1'b1;
              miss_next  = 4'd0;
            end
          end else begin
            stored_next = cand;
            match_next  = 4'd1;
          end
        end else if (timeout) begin
          state_next = SEARCH;
        end
      end
      LOCKED: begin
        // A preamble always beats a simultaneous timeout; the one that trips the miss limit is not reused
        if (valid) begin
          if (cand == ch0_reg) begin
            miss_next = 4'd0;
          end else begin
            miss_next = miss_inc;
`ifdef TDM_SYNC_ERR_CNT_EN
            err_next  = (err_reg == 8'hFF) ? 8'hFF : err_reg + 8'd1;
`endif
            if (miss_inc >= MISS_W) begin
              state_next = SEARCH;
              lock_next  = 1'b0;
              lost_next  = 1'b1;
            end
          end
        end else if (timeout) begin
          state_next = SEARCH;
          lock_next  = 1'b0;
          lost_next  = 1'b1;
        end
      end
      default: begin
        state_next = SEARCH;
        lock_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_108m or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= SEARCH;
      stored_reg <= 2'd0;
      match_reg  <= 4'd0;
      miss_reg   <= 4'd0;
      ch0_reg    <= 2'd0;
      lock_reg   <= 1'b0;
      lost_reg   <= 1'b0;
      sync_reg   <= 1'b0;
      det_id_reg <= 2'd0;
    end else begin
      state_reg  <= state_next;
      stored_reg <= stored_next;
      match_reg  <= match_next;
      miss_reg   <= miss_next;
      ch0_reg    <= ch0_next;
      lock_reg   <= lock_next;
      lost_reg   <= lost_next;
      sync_reg   <= valid;
      if (valid) det_id_reg <= id;
    end
  end

`ifdef TDM_SYNC_ERR_CNT_EN
  always_ff @(posedge clk_108m or negedge rst_n) begin
    if (!rst_n) err_reg <= 8'd0;
    else        err_reg <= err_next;
  end
`endif

  assign slot_cnt  = slot_reg;
  assign ch0_slot  = ch0_reg;
  assign lock      = lock_reg;
  assign lock_lost = lost_reg;
  assign sync_det  = sync_reg;
  assign det_id    = det_id_reg;

endmodule

// File: tb/tb_tdm_sync_ctrl.sv
// Scenario bench for tdm_sync_ctrl: scoreboard of expected sync_det events plus per-scenario lock checks.
module tb_tdm_sync_ctrl;

  localparam int TIMEOUT = 16384;

  logic       clk_108m = 1'b0;
  logic       rst_n;
  logic [7:0] vin_data;
  logic [1:0] slot_cnt, ch0_slot, det_id;
  logic       lock, lock_lost, sync_det;
`ifdef TDM_SYNC_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  tdm_sync_ctrl dut (
    .clk_108m (clk_108m),
    .rst_n    (rst_n),
    .vin_data (vin_data),
    .slot_cnt (slot_cnt),
    .ch0_slot (ch0_slot),
    .lock     (lock),
    .lock_lost(lock_lost),
    .sync_det (sync_det),
    .det_id   (det_id)
`ifdef TDM_SYNC_ERR_CNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clk_108m = ~clk_108m;

  typedef struct {
    logic [1:0] id;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lost_cnt = 0;
  int lost_cyc = 0;
  int sync_cnt = 0;
  int last_xy_cyc = 0;

  // One clock per byte; sampled 1 ns after the edge, consumes scoreboard entries
  task automatic drive_byte(input logic [7:0] b);
    exp_t e;
    vin_data = b;
    @(posedge clk_108m);
    #1;
    cyc++;
    if (lock_lost) begin
      lost_cnt++;
      lost_cyc = cyc;
    end
    if (sync_det) begin
      sync_cnt++;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_sync_det cyc=%0d det_id=%0d required=none", cyc, det_id);
      end else begin
        e = q.pop_front();
        if (det_id !== e.id || cyc != e.cyc) begin
          failures++;
          $display("FAIL sync_det det_id=%0d cyc=%0d required det_id=%0d cyc=%0d", det_id, cyc, e.id, e.cyc);
        end
      end
    end
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_sync_det id=%0d required_cyc=%0d now=%0d", e.id, e.cyc, cyc);
    end
  endtask

  task automatic send_xy(input logic [7:0] b);
    exp_t e;
    if (b[7] && b[3:2] == 2'b00) begin
      e.id = b[1:0];
      e.cyc = cyc + 2;
      q.push_back(e);
    end
    drive_byte(b);
    last_xy_cyc = cyc;
  endtask

  task automatic filler(input int n);
    for (int i = 0; i < n; i++) drive_byte(8'h10);
  endtask

  task automatic pad_to(input int slot);
    while (((cyc + 1) % 4) != slot) drive_byte(8'h10);
  endtask

  // Full 4-channel preamble group; channel j rides slot (p+j) mod 4, so cand == p
  task automatic send_block(input int p);
    pad_to(p);
    for (int i = 0; i < 4; i++) drive_byte(8'hFF);
    for (int i = 0; i < 8; i++) drive_byte(8'h00);
    for (int j = 0; j < 4; j++) send_xy(8'h80 | 8'(j));
  endtask

  // Preamble in one slot only, other slots carry filler
  task automatic send_single(input int slot, input logic [7:0] xy);
    pad_to(slot);
    drive_byte(8'hFF); filler(3);
    drive_byte(8'h00); filler(3);
    drive_byte(8'h00); filler(3);
    send_xy(xy);
  endtask

  task automatic test_reset;
    logic [1:0] exp_slot;
    rst_n = 1'b0;
    vin_data = 8'h10;
    repeat (3) @(posedge clk_108m);
    #1;
    checks++;
    if ({slot_cnt, ch0_slot, lock, lock_lost, sync_det, det_id} !== 9'd0) begin
      failures++;
      $display("FAIL reset_outputs slot=%0d ch0=%0d lock=%0b lost=%0b sync=%0b id=%0d required all 0",
               slot_cnt, ch0_slot, lock, lock_lost, sync_det, det_id);
    end
`ifdef TDM_SYNC_ERR_CNT_EN
    checks++;
    if (err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_err_cnt got=%0d required=0", err_cnt);
    end
`endif
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 6; i++) begin
      drive_byte(8'h10);
      exp_slot = 2'(cyc % 4);
      checks++;
      if (slot_cnt !== exp_slot) begin
        failures++;
        $display("FAIL slot_cnt got=%0d required=%0d", slot_cnt, exp_slot);
      end
    end
  endtask

  task automatic test_lock;
    filler(20);
    send_block(2);
    checks++;
    if (lock !== 1'b0) begin
      failures++;
      $display("FAIL lock_early got=%0b required=0", lock);
    end
    filler(1);
    checks++;
    if (lock !== 1'b1 || ch0_slot !== 2'd2 || lost_cnt != 0) begin
      failures++;
      $display("FAIL lock_acquire lock=%0b ch0=%0d lost=%0d required lock=1 ch0=2 lost=0", lock, ch0_slot, lost_cnt);
    end
  endtask

  task automatic test_rephase;
    int lost0;
    lost0 = lost_cnt;
    filler(40);
    send_block(3);
    filler(2);
    checks++;
    if (lock !== 1'b0 || lost_cnt != lost0 + 1) begin
      failures++;
      $display("FAIL rephase_drop lock=%0b pulses=%0d required lock=0 pulses=1", lock, lost_cnt - lost0);
    end
`ifdef TDM_SYNC_ERR_CNT_EN
    checks++;
    if (err_cnt !== 8'd3) begin
      failures++;
      $display("FAIL rephase_err_cnt got=%0d required=3", err_cnt);
    end
`endif
    filler(40);
    send_block(3);
    filler(2);
    checks++;
    if (lock !== 1'b1 || ch0_slot !== 2'd3) begin
      failures++;
      $display("FAIL relock lock=%0b ch0=%0d required lock=1 ch0=3", lock, ch0_slot);
    end
  endtask

  task automatic test_timeout;
    int lost0;
    logic prev_lock;
    filler(40);
    send_block(3);
    lost0 = lost_cnt;
    prev_lock = 1'b0;
    for (int i = 0; i < TIMEOUT + 64 && lost_cnt == lost0; i++) begin
      prev_lock = lock;
      drive_byte(8'h10);
    end
    checks++;
    if (lost_cnt != lost0 + 1) begin
      failures++;
      $display("FAIL timeout_no_drop pulses=%0d required=1", lost_cnt - lost0);
    end else begin
      checks++;
      if (lost_cyc != last_xy_cyc + TIMEOUT + 2 || prev_lock !== 1'b1 || lock !== 1'b0) begin
        failures++;
        $display("FAIL timeout_edge cyc=%0d prev_lock=%0b lock=%0b required cyc=%0d prev_lock=1 lock=0",
                 lost_cyc, prev_lock, lock, last_xy_cyc + TIMEOUT + 2);
      end
      drive_byte(8'h10);
      checks++;
      if (lock_lost !== 1'b0) begin
        failures++;
        $display("FAIL timeout_pulse_width lock_lost=%0b required=0", lock_lost);
      end
    end
  endtask

  task automatic test_reject;
    int sync0;
    sync0 = sync_cnt;
    send_single(1, 8'h0C);
    send_single(1, 8'h4C);
    send_single(1, 8'h8C);
    filler(3);
    checks++;
    if (sync_cnt != sync0 || lock !== 1'b0) begin
      failures++;
      $display("FAIL reject syncs=%0d lock=%0b required syncs=0 lock=0", sync_cnt - sync0, lock);
    end
`ifdef TDM_SYNC_ERR_CNT_EN
    checks++;
    if (err_cnt !== 8'd3) begin
      failures++;
      $display("FAIL reject_err_cnt got=%0d required=3", err_cnt);
    end
`endif
  endtask

  task automatic test_mixed_verify;
    send_single(1, 8'h80);
    send_single(1, 8'h80);
    for (int i = 0; i < 3; i++) send_single(2, 8'h82);
    filler(2);
    checks++;
    if (lock !== 1'b0) begin
      failures++;
      $display("FAIL mixed_early_lock lock=%0b required=0", lock);
    end
    send_single(2, 8'h82);
    filler(2);
    checks++;
    if (lock !== 1'b1 || ch0_slot !== 2'd0) begin
      failures++;
      $display("FAIL mixed_lock lock=%0b ch0=%0d required lock=1 ch0=0", lock, ch0_slot);
    end
  endtask

  task automatic test_reset_mid_lock;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (lock !== 1'b0 || ch0_slot !== 2'd0 || slot_cnt !== 2'd0 || det_id !== 2'd0 || lock_lost !== 1'b0) begin
      failures++;
      $display("FAIL async_reset lock=%0b ch0=%0d slot=%0d id=%0d lost=%0b required all 0",
               lock, ch0_slot, slot_cnt, det_id, lock_lost);
    end
    @(posedge clk_108m);
    #1;
    checks++;
    if (lock_lost !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_pulse lock_lost=%0b required=0", lock_lost);
    end
    rst_n = 1'b1;
    cyc = 0;
    q.delete();
  endtask

  initial begin
    test_reset();
    test_lock();
    test_rephase();
    test_timeout();
    test_reject();
    test_mixed_verify();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover entries=%0d required=0", q.size());
    end
    test_reset_mid_lock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
